// File: rtl/period_meter.sv
// period_meter: measures the period of an asynchronous periodic input in clk
// cycles. Rising edges of the synchronized input delimit a measurement; the
// result is published on period with a one-cycle valid strobe. A missing edge
// within MAX_COUNT cycles produces a one-cycle timeout strobe and re-arms.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled, count cleared, waiting for en
// ARM     | enabled, waiting for the reference rising edge
// MEASURE | counting clk cycles since the last rising edge
module period_meter #(
  parameter int N         = 26,
  parameter int MAX_COUNT = 49_999_999
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         en,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         measuring
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  // MAX_COUNT must lie in [2, 2^N-1]; the compare below relies on it fitting N bits.
  localparam logic [N-1:0] MAX_C = N'(MAX_COUNT);

  state_t       state;
  logic [N-1:0] count;
  logic         s1, s2, prev;
  logic         rise;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

  // Measurement FSM with the cycle counter and registered result/strobes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      count     <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      measuring <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!en) begin
        // Disabling overrides everything, including a coincident edge.
        state     <= IDLE;
        count     <= '0;
        measuring <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= ARM;
            count     <= '0;
            measuring <= 1'b0;
          end
          ARM: begin
            if (rise) begin
              state     <= MEASURE;
              count     <= N'(1);
              measuring <= 1'b1;
            end else begin
              count <= '0;
            end
          end
          MEASURE: begin
            if (rise) begin
              // An edge landing exactly on MAX_COUNT is still a valid period.
              period <= count;
              valid  <= 1'b1;
              count  <= N'(1);
            end else if (count == MAX_C) begin
              timeout   <= 1'b1;
              count     <= '0;
              state     <= ARM;
              measuring <= 1'b0;
            end else begin
              count <= count + N'(1);
            end
          end
          default: begin
            state     <= IDLE;
            count     <= '0;
            measuring <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: drives sig_in/en/arst on the falling edge,
// predicts strobes from the driven edge times, and checks every cycle.
module tb_period_meter;

  localparam int N   = 26;
  localparam int MAX = 20;

  logic         clk;
  logic         arst;
  logic         en;
  logic         sig_in;
  logic [N-1:0] period;
  logic         valid;
  logic         timeout;
  logic         measuring;

  period_meter #(.N(N), .MAX_COUNT(MAX)) dut (
    .clk       (clk),
    .arst      (arst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout),
    .measuring (measuring)
  );

  typedef struct {
    int cyc;
    bit is_to;
    int per;
  } ev_t;

  ev_t  q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Expected-behaviour state, advanced once per driven cycle.
  logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  bit   ref_valid = 1'b0;
  bit   en_prev   = 1'b0;
  int   last_rise = 0;
  logic meas_next = 1'b0;
  int   per_model = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One driven cycle: update inputs on the falling edge, then predict what
  // the rising edge detected in this cycle leads to.
  task automatic step(input logic v, input logic e, input logic r);
    bit   do_async;
    logic rise;
    @(negedge clk);
    do_async = r && !arst;
    sig_in = v;
    en     = e;
    arst   = r;
    d3 = d2; d2 = d1; d1 = d0; d0 = v;
    if (r) begin
      d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
      ref_valid = 1'b0;
      en_prev   = 1'b0;
      q.delete();
      per_model = 0;
      meas_next = 1'b0;
      if (do_async) begin
        #1;
        chk("async_period", 32'(period), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_timeout", 32'(timeout), 32'd0);
        chk("async_measuring", 32'(measuring), 32'd0);
      end
    end else begin
      rise = d2 & ~d3;
      if (!e) begin
        ref_valid = 1'b0;
      end else if (en_prev) begin
        if (ref_valid && !rise && cyc == last_rise + MAX) begin
          q.push_back('{cyc + 1, 1'b1, 0});
          ref_valid = 1'b0;
        end else if (rise) begin
          if (ref_valid) q.push_back('{cyc + 1, 1'b0, cyc - last_rise});
          last_rise = cyc;
          ref_valid = 1'b1;
        end
      end
      en_prev   = e;
      meas_next = ref_valid;
    end
  endtask

  // Scoreboard: pop the strobe predicted for this cycle and check all outputs.
  always @(posedge clk) begin
    bit exp_v, exp_t;
    cyc++;
    #1;
    exp_v = 1'b0;
    exp_t = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_v = !q[0].is_to;
      exp_t = q[0].is_to;
      if (exp_v) per_model = q[0].per;
      void'(q.pop_front());
    end
    chk("valid", 32'(valid), 32'(exp_v));
    chk("timeout", 32'(timeout), 32'(exp_t));
    chk("period", 32'(period), 32'(per_model));
    chk("measuring", 32'(measuring), 32'(meas_next));
  end

  initial begin
    arst   = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    #1 arst = 1'b1;

    // reset held with sig_in toggling, then released with en low
    for (int i = 0; i < 6; i++) step(i % 2 == 1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(i % 2 == 1, 1'b0, 1'b0);

    // square wave, period 10
    for (int i = 0; i < 80; i++) step((i % 10) < 5, 1'b1, 1'b0);
    // held low: timeout after last edge, then a lone edge and another timeout
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

    // boundary: edges exactly MAX apart, then MAX+1 apart
    for (int i = 0; i < 80; i++) step((i % 20) < 3, 1'b1, 1'b0);
    for (int i = 0; i < 84; i++) step((i % 21) < 3, 1'b1, 1'b0);

    // fastest input: toggling every clk
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 1'b1, 1'b0);
    // period change 10 -> 7
    for (int i = 0; i < 30; i++) step((i % 10) < 5, 1'b1, 1'b0);
    for (int i = 0; i < 21; i++) step((i % 7) < 4, 1'b1, 1'b0);

    // en dropped in the same cycle as a detected edge, then re-enabled
    for (int i = 0; i < 70; i++) begin
      step((i % 10) < 5, !(i >= 32 && i < 37), 1'b0);
      if (i == 36) chk("en_hold", 32'(period), 32'd10);
    end

    // arst mid-measurement
    for (int i = 0; i < 40; i++) step((i % 10) < 5, 1'b1, i >= 23 && i < 26);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
